// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: op and FSM state
// encodings, plus lane helpers for big-endian (offset 0 = bits [31:24]) words.
package mips_mem_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LW);
    endfunction

    // Clear the low address bits a halfword/word access is not allowed to use.
    function automatic logic [31:0] align_addr(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            OP_LH, OP_LHU, OP_SH: return {addr[31:1], 1'b0};
            OP_LW, OP_SW:         return {addr[31:2], 2'b00};
            default:              return addr;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return |off;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [15:0] get_half(input logic [31:0] w, input logic h);
        return h ? w[15:0] : w[31:16];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        case (k)
            2'd0:    return {b, w[23:0]};
            2'd1:    return {w[31:24], b, w[15:0]};
            2'd2:    return {w[31:16], b, w[7:0]};
            default: return {w[31:8], b};
        endcase
    endfunction

    function automatic logic [31:0] put_half(input logic [31:0] w, input logic h,
                                             input logic [15:0] hw);
        return h ? {w[31:16], hw} : {hw, w[15:0]};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extract + sign/zero-extend for loads, and merge of
// the right-justified store lane into the fetched word for sub-word stores.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = get_byte(rdata, offset);
    assign lane_h = get_half(rdata, offset[1]);

    // Load extraction and extension
    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        load_data = rdata;
        case (op)
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'h0, lane_b};
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase
    end

    // Read-modify-write merge for sub-word stores
    always_comb begin
        merge_data = wdata;
        case (op)
            OP_SB:   merge_data = put_byte(rdata, offset, wdata[7:0]);
            OP_SH:   merge_data = put_half(rdata, offset[1], wdata[15:0]);
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of a word-wide data memory.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are reported via misalign_err instead of being
// silently aligned down.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;

    logic [31:0] addr_al;
    logic        out_of_range;
    logic        trap;
    logic        err_flag;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign addr_al      = align_addr(req_op, req_addr);
    assign out_of_range = ({2'b00, addr_al[31:2]} >= MEM_WORDS);

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    assign trap     = is_misaligned(req_op, req_addr[1:0]);
    assign err_flag = err_q;
`else
    assign trap     = 1'b0;
    assign err_flag = 1'b0;
`endif

    // Strobes and handshakes are pure decodes of the state register.
    assign req_ready    = (state == ST_IDLE);
    assign mem_read     = (state == ST_RD) || (state == ST_RMW_RD);
    assign mem_write    = (state == ST_WR);
    assign resp_valid   = (state == ST_RESP);
    assign resp_we      = resp_valid && is_load(op_q) && !err_flag;
    assign misalign_err = resp_valid && err_flag;

    mem_lane_align u_lane (
        .op         (op_q),
        .offset     (offset_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Sequencer: capture on accept, then read / merge / write / respond.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, so every output is defined straight after reset.
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= 3'd0;
            offset_q   <= 2'd0;
            wdata_q    <= 32'h0;
            resp_rd    <= 5'd0;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        offset_q   <= addr_al[1:0];
                        wdata_q    <= req_wdata;
                        resp_rd    <= req_rd;
                        resp_rdata <= 32'h0;
                        mem_addr   <= {2'b00, addr_al[31:2]};
                        if (req_op == OP_SW) begin
                            mem_wdata <= req_wdata;
                        end
`ifdef MISALIGN_TRAP_EN
                        err_q <= trap;
`endif
                        if (trap || out_of_range) begin
                            state <= ST_RESP;
                        end else if (is_load(req_op)) begin
                            state <= ST_RD;
                        end else if (req_op == OP_SW) begin
                            state <= ST_WR;
                        end else begin
                            state <= ST_RMW_RD;
                        end
                    end
                end
                ST_RD: begin
                    resp_rdata <= load_data;
                    state      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_wdata <= merge_data;
                    state     <= ST_WR;
                end
                ST_WR: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
`ifdef MISALIGN_TRAP_EN
                    err_q <= 1'b0;
`endif
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of requests with hand-computed
// results against a 10-word memory model, plus reset and reset-mid-RMW sequences.
module tb_mem_access_unit;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:9];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd10) ? mem[mem_addr[3:0]] : 32'hDEAD_DEAD;

    mem_access_unit #(.MEM_WORDS(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_we      (resp_we),
        .resp_rd      (resp_rd),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] maddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                                input int n_rd, input int n_wr, input logic [31:0] maddr,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                                input logic exp_we, input logic exp_err);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.lat = lat; v.n_rd = n_rd; v.n_wr = n_wr; v.maddr = maddr;
        v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_we = exp_we; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one request at a negedge and follow it to one cycle past its response.
    task automatic run_vec(input vec_t v);
        int          lat;
        int          n_rd;
        int          n_wr;
        int          n_both;
        int          n_rdy;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] got_rdata;
        logic [4:0]  got_rd;
        logic        got_we;
        logic        got_err;
        lat = 0; n_rd = 0; n_wr = 0; n_both = 0; n_rdy = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        got_rdata = '0; got_rd = '0; got_we = 1'b0; got_err = 1'b0;

        check({v.name, " ready"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_read) begin
                n_rd++;
                rd_addr = mem_addr;
            end
            if (mem_write) begin
                n_wr++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
                if (mem_addr < 32'd10) mem[mem_addr[3:0]] = mem_wdata;
            end
            if (mem_read && mem_write) n_both++;
            if (req_ready) n_rdy++;
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_rd    = resp_rd;
                got_we    = resp_we;
                got_err   = misalign_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);

        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " read cycles"}, n_rd, v.n_rd);
        check({v.name, " write cycles"}, n_wr, v.n_wr);
        check({v.name, " rd&wr overlap"}, n_both, 32'd0);
        check({v.name, " ready while busy"}, n_rdy, 32'd0);
        if (v.n_rd > 0) check({v.name, " read addr"}, rd_addr, v.maddr);
        if (v.n_wr > 0) begin
            check({v.name, " write addr"}, wr_addr, v.maddr);
            check({v.name, " write data"}, wr_data, v.exp_wdata);
        end
        check({v.name, " rdata"}, got_rdata, v.exp_rdata);
        check({v.name, " we"}, {31'h0, got_we}, {31'h0, v.exp_we});
        check({v.name, " err"}, {31'h0, got_err}, {31'h0, v.exp_err});
        check({v.name, " resp_rd"}, {27'h0, got_rd}, {27'h0, v.rd});
        check({v.name, " after resp"}, {28'h0, resp_valid, req_ready, mem_read, mem_write},
              32'b0100);
    endtask

    initial begin
        int spurious;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;
        mem[0] = 32'h0A0A_0000; mem[1] = 32'h0000_0002; mem[2] = 32'h0000_8000;
        mem[3] = 32'h89AB_CDEF; mem[4] = 32'h1357_9BDF;
        for (int i = 5; i < 10; i++) mem[i] = 32'h0;

        //            name           op   addr          wdata         rd lat rd wr maddr wdata         rdata         we err
        vecs.push_back(mk("lw_w1",       LW,  32'h4,        32'h0,        5,  2, 1, 0, 1, 32'h0,        32'h0000_0002, 1, 0));
        vecs.push_back(mk("lb_neg",      LB,  32'hA,        32'h0,        1,  2, 1, 0, 2, 32'h0,        32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk("lbu_pos",     LBU, 32'hA,        32'h0,        2,  2, 1, 0, 2, 32'h0,        32'h0000_0080, 1, 0));
        vecs.push_back(mk("lh_neg",      LH,  32'hA,        32'h0,        3,  2, 1, 0, 2, 32'h0,        32'hFFFF_8000, 1, 0));
        vecs.push_back(mk("lhu_h1",      LHU, 32'hE,        32'h0,        4,  2, 1, 0, 3, 32'h0,        32'h0000_CDEF, 1, 0));
        vecs.push_back(mk("lb_b0",       LB,  32'hC,        32'h0,        6,  2, 1, 0, 3, 32'h0,        32'hFFFF_FF89, 1, 0));
        vecs.push_back(mk("lbu_b3",      LBU, 32'hF,        32'h0,        7,  2, 1, 0, 3, 32'h0,        32'h0000_00EF, 1, 0));
        vecs.push_back(mk("sb_b1",       SB,  32'h1,        32'h1234_56FF, 8, 3, 1, 1, 0, 32'h0AFF_0000, 32'h0,        0, 0));
        vecs.push_back(mk("lw_after_sb", LW,  32'h0,        32'h0,        9,  2, 1, 0, 0, 32'h0,        32'h0AFF_0000, 1, 0));
        vecs.push_back(mk("sh_h1",       SH,  32'h6,        32'hABCD_1234, 10, 3, 1, 1, 1, 32'h0000_1234, 32'h0,       0, 0));
        vecs.push_back(mk("lw_after_sh", LW,  32'h4,        32'h0,        11, 2, 1, 0, 1, 32'h0,        32'h0000_1234, 1, 0));
        vecs.push_back(mk("sw_w2",       SW,  32'h8,        32'hDEAD_BEEF, 12, 2, 0, 1, 2, 32'hDEAD_BEEF, 32'h0,       0, 0));
        vecs.push_back(mk("lw_after_sw", LW,  32'h8,        32'h0,        13, 2, 1, 0, 2, 32'h0,        32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk("sw_last",     SW,  32'h24,       32'h5A5A_5A5A, 14, 2, 0, 1, 9, 32'h5A5A_5A5A, 32'h0,       0, 0));
        vecs.push_back(mk("lw_last",     LW,  32'h24,       32'h0,        15, 2, 1, 0, 9, 32'h0,        32'h5A5A_5A5A, 1, 0));
        vecs.push_back(mk("lw_oor",      LW,  32'h28,       32'h0,        16, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0));
        vecs.push_back(mk("sb_oor",      SB,  32'h28,       32'h0000_00FF, 17, 1, 0, 0, 0, 32'h0,       32'h0,        0, 0));
        vecs.push_back(mk("lw_oor_top",  LW,  32'hFFFF_FFFC, 32'h0,       22, 1, 0, 0, 0, 32'h0,        32'h0,        1, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis",      LW,  32'h2,        32'h0,        18, 1, 0, 0, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk("lh_mis",      LH,  32'hB,        32'h0,        19, 1, 0, 0, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk("sh_mis",      SH,  32'h3,        32'h0000_7777, 20, 1, 0, 0, 0, 32'h0,       32'h0,        0, 1));
        vecs.push_back(mk("lw_w0",       LW,  32'h0,        32'h0,        21, 2, 1, 0, 0, 32'h0,        32'h0AFF_0000, 1, 0));
`else
        vecs.push_back(mk("lw_mis",      LW,  32'h2,        32'h0,        18, 2, 1, 0, 0, 32'h0,        32'h0AFF_0000, 1, 0));
        vecs.push_back(mk("lh_mis",      LH,  32'hB,        32'h0,        19, 2, 1, 0, 2, 32'h0,        32'hFFFF_BEEF, 1, 0));
        vecs.push_back(mk("sh_mis",      SH,  32'h3,        32'h0000_7777, 20, 3, 1, 1, 0, 32'h0AFF_7777, 32'h0,      0, 0));
        vecs.push_back(mk("lw_w0",       LW,  32'h0,        32'h0,        21, 2, 1, 0, 0, 32'h0,        32'h0AFF_7777, 1, 0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'h0, req_ready}, 32'd1);
        check("reset strobes", {27'h0, resp_valid, resp_we, mem_read, mem_write, misalign_err},
              32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_rd", {27'h0, resp_rd}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven requests, issued back to back
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while an SB is in its read phase: the write must never happen
        req_valid = 1'b1;
        req_op    = SB;
        req_addr  = 32'h10;
        req_wdata = 32'h0000_00AA;
        req_rd    = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_reset in rmw_rd", {30'h0, mem_read, mem_write}, 32'b10);
        reset = 1'b1;
        @(negedge clk);
        check("rmw_reset idle", {29'h0, req_ready, mem_write, resp_valid}, 32'b100);
        reset = 1'b0;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_write || mem_read || resp_valid) spurious++;
            @(negedge clk);
        end
        check("rmw_reset no activity", spurious, 32'd0);
        run_vec(mk("lw_after_rst", LW, 32'h10, 32'h0, 23, 2, 1, 0, 4, 32'h0, 32'h1357_9BDF, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
